data_cache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store port and the 4-word-line data memory backing store.
- Serves read hits in the same cycle and stalls the CPU on read misses and on all writes.
- Drives the memory's rd_en_dm/wr_en_dm handshake and waits for its one-cycle done pulse; on a read miss it fills a whole 128-bit line.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_line_array.sv | 51 +++++
 rtl/data_cache_controller.sv | 143 ++++++++++++++
 tb/tb_data_cache_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache controller.
package dcache_pkg;

    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 2;
    localparam int ADDR_W   = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } dcache_state_t;

    // Word k of a line lives in bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] line_word(
        input logic [LINE_W-1:0]   line,
        input logic [OFFSET_W-1:0] k
    );
        return line[int'(k) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache. Only the valid bits
// are reset; tag and data contents are meaningless until a fill sets valid.
module dcache_line_array #(
    parameter int NUM_LINES = 32,
    parameter int INDEX_W   = $clog2(NUM_LINES),
    parameter int TAG_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [127:0]       rd_line,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [127:0]       fill_line,
    input  logic               word_en,
    input  logic [1:0]         word_sel,
    input  logic [31:0]        word_data
);
    import dcache_pkg::*;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_store  [NUM_LINES];
    logic [LINE_W-1:0]    data_store [NUM_LINES];

    // Valid bits: cleared on reset, set by a line fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data: full-line fill takes precedence over a single-word update.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_store[wr_index]  <= fill_tag;
            data_store[wr_index] <= fill_line;
        end else if (word_en) begin
            data_store[wr_index][int'(word_sel) * WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_store[rd_index];
    assign rd_line  = data_store[rd_index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | serve read hits combinationally; launch misses and stores
//   READ_MISS | rd_en_dm high, waiting for mem_done, then fill the line
//   WRITE     | wr_en_dm high, waiting for mem_done for the word write
module data_cache_controller #(
    parameter int NUM_LINES = 32,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              rd_en_dm,
    output logic              wr_en_dm,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [127:0]      mem_data_out,
    input  logic              mem_done
);
    import dcache_pkg::*;

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

    dcache_state_t state;
    dcache_state_t state_next;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag_in;
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [LINE_W-1:0]   line_data;
    logic                hit;
    logic                fill_en;
    logic                word_en;
    logic                wr_done;

    assign offset = cpu_address[OFFSET_W-1:0];
    assign index  = cpu_address[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag_in = cpu_address[ADDR_W-1:INDEX_W+OFFSET_W];
    assign hit    = line_valid && (line_tag == tag_in);

    assign mem_address = cpu_address;
    assign mem_data_in = cpu_wdata;

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (index),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_line   (line_data),
        .wr_index  (index),
        .fill_en   (fill_en),
        .fill_tag  (tag_in),
        .fill_line (mem_data_out),
        .word_en   (word_en),
        .word_sel  (offset),
        .word_data (cpu_wdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Marks the single IDLE cycle after a store completes, so the still-held
    // cpu_wr is released instead of being taken as a fresh store.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_done <= 1'b0;
        end else begin
            wr_done <= (state == WRITE) && mem_done;
        end
    end

    // Next-state, stall, read data and array write strobes.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        cpu_rdata  = '0;
        fill_en    = 1'b0;
        word_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_rd) begin
                    if (hit) begin
                        cpu_rdata = line_word(line_data, offset);
                    end else begin
                        stall      = 1'b1;
                        state_next = READ_MISS;
                    end
                end else if (cpu_wr && !wr_done) begin
                    stall      = 1'b1;
                    state_next = WRITE;
                    word_en    = hit;
                end
            end
            READ_MISS: begin
                stall = 1'b1;
                if (mem_done) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            stall   = 1'b0;
            fill_en = 1'b0;
            word_en = 1'b0;
        end
    end

    // Memory strobes come from the registered state, forced low during reset.
    assign rd_en_dm = (state == READ_MISS) && !rst;
    assign wr_en_dm = (state == WRITE) && !rst;

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller: a 4-beat memory model, a
// reference cache/memory model that predicts each request's outcome, and a
// monitor that checks every completed request against the prediction.
module tb_data_cache_controller;

    localparam int NL  = 32;
    localparam int MEM = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_rd = 1'b0;
    logic         cpu_wr = 1'b0;
    logic [9:0]   cpu_address = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         rd_en_dm;
    logic         wr_en_dm;
    logic [9:0]   mem_address;
    logic [31:0]  mem_data_in;
    logic [127:0] mem_data_out = '0;
    logic         mem_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    data_cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .rd_en_dm     (rd_en_dm),
        .wr_en_dm     (wr_en_dm),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_done     (mem_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model (4 beats, then a one-cycle done) -------
    logic [31:0] mem [MEM];
    int beat = 0;
    logic [9:0] base;

    always @(posedge clk) begin
        if (rst) begin
            beat = 0;
            mem_done <= 1'b0;
            mem_data_out <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end else if ((rd_en_dm || wr_en_dm) && !mem_done) begin
            if (beat == 3) begin
                beat = 0;
                mem_done <= 1'b1;
                if (wr_en_dm) mem[mem_address] = mem_data_in;
                base = {mem_address[9:2], 2'b00};
                mem_data_out <= {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
            end else begin
                beat++;
            end
        end else begin
            mem_done <= 1'b0;
            mem_data_out <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    // ---------------- reference model + scoreboard ------------------------
    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        int          stalls;
        int          rd_cycles;
        int          wr_cycles;
        logic [9:0]  addr;
    } exp_t;

    exp_t        sb_q[$];
    bit          ref_valid [NL];
    int          ref_tag   [NL];
    logic [31:0] ref_mem   [MEM];

    task automatic ref_clear();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic predict(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        int   tg;
        bit   hit;
        idx = (int'(a) / 4) % NL;
        tg  = int'(a) / (4 * NL);
        e.addr = a;
        if (rd) begin
            hit         = ref_valid[idx] && (ref_tag[idx] == tg);
            e.is_rd     = 1'b1;
            e.rdata     = ref_mem[a];
            e.stalls    = hit ? 0 : 6;
            e.rd_cycles = hit ? 0 : 5;
            e.wr_cycles = 0;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end else if (wr) begin
            ref_mem[a]  = d;
            e.is_rd     = 1'b0;
            e.rdata     = '0;
            e.stalls    = 6;
            e.rd_cycles = 0;
            e.wr_cycles = 5;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: accumulates per-request activity and checks on completion.
    int m_stall = 0;
    int m_rd    = 0;
    int m_wr    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_stall = 0;
            m_rd    = 0;
            m_wr    = 0;
        end else if (cpu_rd || cpu_wr) begin
            if (stall) begin
                m_stall++;
                if (rd_en_dm) m_rd++;
                if (wr_en_dm) m_wr++;
            end else begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: addr 0x%0h with no expectation queued", cpu_address);
                end else begin
                    e = sb_q.pop_front();
                    chk("stall_cycles", 64'(m_stall), 64'(e.stalls));
                    chk("rd_en_cycles", 64'(m_rd), 64'(e.rd_cycles));
                    chk("wr_en_cycles", 64'(m_wr), 64'(e.wr_cycles));
                    if (e.is_rd) chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
                    else         chk("mem_word_written", 64'(mem[e.addr]), 64'(ref_mem[e.addr]));
                end
                m_stall = 0;
                m_rd    = 0;
                m_wr    = 0;
            end
        end
    end

    // Protocol watch: the request must not change while stalled.
    logic        p_stall = 1'b0;
    logic [43:0] p_req   = '0;

    always @(negedge clk) begin
        if (!rst && p_stall)
            chk("req_stable_in_stall", 64'({cpu_rd, cpu_wr, cpu_address, cpu_wdata}), 64'(p_req));
        p_stall = stall && !rst;
        p_req   = {cpu_rd, cpu_wr, cpu_address, cpu_wdata};
    end

    // ---------------- driver ---------------------------------------------
    // Called and returns at posedge + 1.
    task automatic do_req(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        predict(rd, wr, a, d);
        cpu_rd      = rd;
        cpu_wr      = wr;
        cpu_address = a;
        cpu_wdata   = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: addr 0x%0h still stalled after 40 cycles", a);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            @(posedge clk); #1;
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
            rst    = 1'b1;
            ref_clear();
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_wdata = $urandom();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < MEM; i++) begin
            v = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'd1;         ref_mem[5] = 32'd1;
        mem[6] = 32'd2;         ref_mem[6] = 32'd2;
        mem[7] = 32'd3;         ref_mem[7] = 32'd3;
        ref_clear();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [9:0] a;

        // Reset behaviour.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rd_en", 64'(rd_en_dm), 64'd0);
        chk("rst_wr_en", 64'(wr_en_dm), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", 64'(stall), 64'd0);
        chk("idle_rdata", 64'(cpu_rdata), 64'd0);
        @(posedge clk); #1;

        // Cold miss then hits on the same line.
        do_req(1, 0, 10'h004, '0);
        do_req(1, 0, 10'h005, '0);
        do_req(1, 0, 10'h006, '0);
        do_req(1, 0, 10'h007, '0);

        // Conflict on the same index.
        do_req(1, 0, 10'h084, '0);
        do_req(1, 0, 10'h004, '0);

        // Write hit, then read back as a hit.
        do_req(0, 1, 10'h005, 32'h1234_5678);
        do_req(1, 0, 10'h005, '0);

        // Write miss: no allocate, so the following read misses.
        do_req(0, 1, 10'h200, 32'hA5A5_A5A5);
        do_req(1, 0, 10'h200, '0);

        // Reset in the middle of a read miss.
        cpu_rd = 1'b1;
        cpu_address = 10'h300;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmr_rd_en_active", 64'(rd_en_dm), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmr_rd_en_in_rst", 64'(rd_en_dm), 64'd0);
        chk("rmr_stall_in_rst", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cpu_rd = 1'b0;
        ref_clear();
        @(negedge clk);
        chk("rmr_rd_en_after", 64'(rd_en_dm), 64'd0);
        chk("rmr_wr_en_after", 64'(wr_en_dm), 64'd0);
        chk("rmr_stall_after", 64'(stall), 64'd0);
        @(posedge clk); #1;
        do_req(1, 0, 10'h300, '0);

        // Read and write together on a hit: read wins, memory untouched.
        do_req(1, 0, 10'h004, '0);
        do_req(1, 1, 10'h004, 32'hFFFF_0000);
        chk("both_mem_unchanged", 64'(mem[4]), 64'(ref_mem[4]));
        do_req(1, 0, 10'h004, '0);

        // Randomised traffic over a few indices and tags for hits and conflicts.
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            a = 10'(($urandom_range(0, 7) << 7) | $urandom_range(0, 15));
            if (r < 6)      do_req(1, 0, a, $urandom());
            else if (r < 9) do_req(0, 1, a, $urandom());
            else            do_req(1, 1, a, $urandom());
        end

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
